mips_control_fsm: RTL and testbench

- Multi-cycle (non-pipelined) MIPS main control unit.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every enable and mux select of the multi-cycle datapath: PC, instruction register, register file write port, extenders, ALU and PC source muxes.
- Talks to a unified instruction/data memory through a request/ready handshake, so memory latency is variable.

---
 rtl/mips_control_fsm_if.sv | 53 +++++
 rtl/mips_control_fsm.sv | 248 ++++++++++++++++++++++++
 tb/tb_mips_control_fsm.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_control_fsm_if.sv
// Control bus between the multi-cycle MIPS control FSM and its datapath.
//
// Signals:
//   opcode, funct   instruction register fields, from datapath
//   zero            ALU zero flag, from datapath
//   mem_ready       unified memory has completed the current access
//   pc_write .. pc_src, illegal_op
//                   enables and mux selects, from the control FSM
//   state           current FSM state, for debug
//
// Modports:
//   master  the control FSM (drives the enables and selects)
//   slave   the datapath/memory side (drives opcode, funct, zero and mem_ready)
interface mips_control_fsm_if #(
   parameter int OPCODE_WIDTH = 6,
   parameter int FUNCT_WIDTH  = 6,
   parameter int STATE_WIDTH  = 4
);
   logic [OPCODE_WIDTH-1:0] opcode;
   logic [FUNCT_WIDTH-1:0]  funct;
   logic                    zero;
   logic                    mem_ready;

   logic                    pc_write;
   logic                    instr_write;
   logic                    reg_write;
   logic                    mem_read;
   logic                    mem_write;
   logic                    iord;
   logic                    mem_to_reg;
   logic                    reg_dst;
   logic                    imm_zext;
   logic                    alu_src_a;
   logic [1:0]              alu_src_b;
   logic [2:0]              alu_control;
   logic [1:0]              pc_src;
   logic                    illegal_op;
   logic [STATE_WIDTH-1:0]  state;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output pc_write, instr_write, reg_write, mem_read, mem_write, iord,
             mem_to_reg, reg_dst, imm_zext, alu_src_a, alu_src_b,
             alu_control, pc_src, illegal_op, state
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  pc_write, instr_write, reg_write, mem_read, mem_write, iord,
             mem_to_reg, reg_dst, imm_zext, alu_src_a, alu_src_b,
             alu_control, pc_src, illegal_op, state
   );
endinterface

// File: rtl/mips_control_fsm.sv
// Main control unit of a multi-cycle (non-pipelined) MIPS processor.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives every enable and mux select of the datapath. Memory is accessed via
// a request (mem_read/mem_write) and mem_ready handshake, so FETCH, MEMREAD
// and MEMWRITE stall for as long as the memory needs.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; while high all outputs read 0
//   ctl   control bus (mips_control_fsm_if.master): instruction fields, zero
//         flag and mem_ready in; enables, selects, illegal_op and state out
module mips_control_fsm #(
   parameter int OPCODE_WIDTH = 6,
   parameter int FUNCT_WIDTH  = 6,
   parameter int STATE_WIDTH  = 4
) (
   input  logic                clk,
   input  logic                rst,
   mips_control_fsm_if.master  ctl
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_IMMEXEC  = 4'd9,
      S_IMMWB    = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'h00);
   localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'h02);
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'h04);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'h08);
   localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = OPCODE_WIDTH'(6'h0C);
   localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = OPCODE_WIDTH'(6'h0D);
   localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'h23);
   localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'h2B);

   localparam logic [FUNCT_WIDTH-1:0]  FN_ADD   = FUNCT_WIDTH'(6'h20);
   localparam logic [FUNCT_WIDTH-1:0]  FN_SUB   = FUNCT_WIDTH'(6'h22);
   localparam logic [FUNCT_WIDTH-1:0]  FN_AND   = FUNCT_WIDTH'(6'h24);
   localparam logic [FUNCT_WIDTH-1:0]  FN_OR    = FUNCT_WIDTH'(6'h25);
   localparam logic [FUNCT_WIDTH-1:0]  FN_SLT   = FUNCT_WIDTH'(6'h2A);

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t state_reg;
   state_t state_next;

   // Instruction decode helpers
   logic       funct_ok;
   logic [2:0] r_alu;
   logic [2:0] i_alu;
   logic       i_zext;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   // ALU operation for R-type instructions, from funct.
   always_comb begin
      funct_ok = 1'b1;
      r_alu    = ALU_ADD;
      case (ctl.funct)
         FN_ADD:  r_alu = ALU_ADD;
         FN_SUB:  r_alu = ALU_SUB;
         FN_AND:  r_alu = ALU_AND;
         FN_OR:   r_alu = ALU_OR;
         FN_SLT:  r_alu = ALU_SLT;
         default: funct_ok = 1'b0;
      endcase
   end

   // ALU operation and extender mode for immediate arithmetic; shared by
   // IMMEXEC and IMMWB so the ALU register path is unchanged during writeback.
   always_comb begin
      i_alu  = ALU_ADD;
      i_zext = 1'b0;
      case (ctl.opcode)
         OP_ANDI: begin
            i_alu  = ALU_AND;
            i_zext = 1'b1;
         end
         OP_ORI: begin
            i_alu  = ALU_OR;
            i_zext = 1'b1;
         end
         default: begin
            i_alu  = ALU_ADD;
            i_zext = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_next      = state_reg;
      ctl.pc_write    = 1'b0;
      ctl.instr_write = 1'b0;
      ctl.reg_write   = 1'b0;
      ctl.mem_read    = 1'b0;
      ctl.mem_write   = 1'b0;
      ctl.iord        = 1'b0;
      ctl.mem_to_reg  = 1'b0;
      ctl.reg_dst     = 1'b0;
      ctl.imm_zext    = 1'b0;
      ctl.alu_src_a   = 1'b0;
      ctl.alu_src_b   = 2'b00;
      ctl.alu_control = 3'b000;
      ctl.pc_src      = 2'b00;
      ctl.illegal_op  = 1'b0;

      case (state_reg)
         S_FETCH: begin
            ctl.mem_read    = 1'b1;
            ctl.alu_src_b   = 2'b01;
            ctl.alu_control = ALU_ADD;
            // IR load and PC+4 commit only on the cycle the read completes.
            ctl.instr_write = ctl.mem_ready;
            ctl.pc_write    = ctl.mem_ready;
            if (ctl.mem_ready) begin
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            // Speculatively compute the branch target into the ALU register.
            ctl.alu_src_b   = 2'b11;
            ctl.alu_control = ALU_ADD;
            case (ctl.opcode)
               OP_LW, OP_SW:            state_next = S_MEMADR;
               OP_BEQ:                  state_next = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI: state_next = S_IMMEXEC;
               OP_J:                    state_next = S_JUMP;
               OP_RTYPE: begin
                  if (funct_ok) begin
                     state_next = S_EXECUTE;
                  end else begin
                     ctl.illegal_op = 1'b1;
                     state_next     = S_FETCH;
                  end
               end
               default: begin
                  ctl.illegal_op = 1'b1;
                  state_next     = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ctl.alu_src_a   = 1'b1;
            ctl.alu_src_b   = 2'b10;
            ctl.alu_control = ALU_ADD;
            state_next      = (ctl.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            ctl.mem_read = 1'b1;
            ctl.iord     = 1'b1;
            if (ctl.mem_ready) begin
               state_next = S_MEMWB;
            end
         end
         S_MEMWB: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = 1'b1;
            state_next     = S_FETCH;
         end
         S_MEMWRITE: begin
            ctl.mem_write = 1'b1;
            ctl.iord      = 1'b1;
            if (ctl.mem_ready) begin
               state_next = S_FETCH;
            end
         end
         S_EXECUTE: begin
            ctl.alu_src_a   = 1'b1;
            ctl.alu_control = r_alu;
            state_next      = S_ALUWB;
         end
         S_ALUWB: begin
            ctl.reg_write = 1'b1;
            ctl.reg_dst   = 1'b1;
            state_next    = S_FETCH;
         end
         S_BRANCH: begin
            ctl.alu_src_a   = 1'b1;
            ctl.alu_control = ALU_SUB;
            ctl.pc_src      = 2'b01;
            ctl.pc_write    = ctl.zero;
            state_next      = S_FETCH;
         end
         S_IMMEXEC: begin
            ctl.alu_src_a   = 1'b1;
            ctl.alu_src_b   = 2'b10;
            ctl.alu_control = i_alu;
            ctl.imm_zext    = i_zext;
            state_next      = S_IMMWB;
         end
         S_IMMWB: begin
            ctl.reg_write   = 1'b1;
            ctl.alu_control = i_alu;
            ctl.imm_zext    = i_zext;
            state_next      = S_FETCH;
         end
         S_JUMP: begin
            ctl.pc_write = 1'b1;
            ctl.pc_src   = 2'b10;
            state_next   = S_FETCH;
         end
         default: begin
            state_next = S_FETCH;
         end
      endcase

      // Reset cycle: abandon the instruction with every strobe low.
      if (rst) begin
         ctl.pc_write    = 1'b0;
         ctl.instr_write = 1'b0;
         ctl.reg_write   = 1'b0;
         ctl.mem_read    = 1'b0;
         ctl.mem_write   = 1'b0;
         ctl.iord        = 1'b0;
         ctl.mem_to_reg  = 1'b0;
         ctl.reg_dst     = 1'b0;
         ctl.imm_zext    = 1'b0;
         ctl.alu_src_a   = 1'b0;
         ctl.alu_src_b   = 2'b00;
         ctl.alu_control = 3'b000;
         ctl.pc_src      = 2'b00;
         ctl.illegal_op  = 1'b0;
      end
   end

   assign ctl.state = rst ? '0 : STATE_WIDTH'(state_reg);

endmodule

// File: tb/tb_mips_control_fsm.sv
module tb_mips_control_fsm;

   typedef struct packed {
      logic       pc_write;
      logic       instr_write;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       imm_zext;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic [1:0] pc_src;
      logic       illegal_op;
   } ctl_t;

   typedef struct packed {
      logic [3:0] st;
      ctl_t       c;
   } exp_t;

   logic clk;
   logic rst;
   mips_control_fsm_if ctl_if ();

   mips_control_fsm dut (
      .clk (clk),
      .rst (rst),
      .ctl (ctl_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks_cnt = 0;
   int   errors_cnt = 0;
   exp_t exp_q[$];
   int   m_state = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks_cnt++;
      if (obs !== expv) begin
         errors_cnt++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
      end
   endtask

   // ---------------- reference model, written from the state table ----------
   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'h00)
         return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2A);
      return (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h08) ||
             (op == 6'h0C) || (op == 6'h0D) || (op == 6'h02);
   endfunction

   function automatic logic [2:0] r_op(input logic [5:0] fn);
      case (fn)
         6'h22:   return 3'b110;
         6'h24:   return 3'b000;
         6'h25:   return 3'b001;
         6'h2A:   return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   function automatic ctl_t model_ctl(input int s, input logic [5:0] op, input logic [5:0] fn,
                                      input logic z, input logic rdy);
      ctl_t c;
      c = '0;
      case (s)
         0: begin
            c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_control = 3'b010;
            c.instr_write = rdy; c.pc_write = rdy;
         end
         1: begin
            c.alu_src_b = 2'b11; c.alu_control = 3'b010; c.illegal_op = !is_legal(op, fn);
         end
         2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_control = 3'b010; end
         3: begin c.mem_read = 1; c.iord = 1; end
         4: begin c.reg_write = 1; c.mem_to_reg = 1; end
         5: begin c.mem_write = 1; c.iord = 1; end
         6: begin c.alu_src_a = 1; c.alu_control = r_op(fn); end
         7: begin c.reg_write = 1; c.reg_dst = 1; end
         8: begin c.alu_src_a = 1; c.alu_control = 3'b110; c.pc_src = 2'b01; c.pc_write = z; end
         9, 10: begin
            if (s == 9) begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            else c.reg_write = 1;
            c.alu_control = (op == 6'h0C) ? 3'b000 : (op == 6'h0D) ? 3'b001 : 3'b010;
            c.imm_zext    = (op == 6'h0C) || (op == 6'h0D);
         end
         11: begin c.pc_write = 1; c.pc_src = 2'b10; end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic int model_next(input int s, input logic [5:0] op, input logic [5:0] fn,
                                     input logic rdy);
      case (s)
         0: return rdy ? 1 : 0;
         1: begin
            if (!is_legal(op, fn)) return 0;
            if (op == 6'h23 || op == 6'h2B) return 2;
            if (op == 6'h00) return 6;
            if (op == 6'h04) return 8;
            if (op == 6'h02) return 11;
            return 9;
         end
         2: return (op == 6'h2B) ? 5 : 3;
         3: return rdy ? 4 : 3;
         5: return rdy ? 0 : 5;
         6: return 7;
         9: return 10;
         default: return 0;
      endcase
   endfunction

   // ---------------- driver: one clock cycle, expectation queued -------------
   task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy);
      exp_t e;
      int   nxt;
      rst              = r;
      ctl_if.opcode    = op;
      ctl_if.funct     = fn;
      ctl_if.zero      = z;
      ctl_if.mem_ready = rdy;
      if (r) begin
         e.st = 4'd0;
         e.c  = '0;
         nxt  = 0;
      end else begin
         e.st = 4'(m_state);
         e.c  = model_ctl(m_state, op, fn, z, rdy);
         nxt  = model_next(m_state, op, fn, rdy);
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      m_state = nxt;
   endtask

   // Runs one instruction for a fixed cycle count taken from the timing table,
   // then checks the DUT is back in FETCH.
   task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int fetch_waits, input int mem_waits,
                            input int cycles);
      int   fw;
      int   mw;
      logic rdy;
      logic zc;
      fw = 0;
      mw = 0;
      for (int i = 0; i < cycles; i++) begin
         case (m_state)
            0: begin rdy = (fw >= fetch_waits); fw++; end
            3, 5: begin rdy = (mw >= mem_waits); mw++; end
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         zc = (m_state == 8) ? z : 1'($urandom_range(0, 1));
         step(1'b0, op, fn, zc, rdy);
      end
      #2;
      check({name, "_end_state"}, 32'(ctl_if.state), 32'd0);
      $display("instr %s op=%h funct=%h zero=%0d cycles=%0d", name, op, fn, z, cycles);
   endtask

   // ---------------- monitor: compare on the falling edge --------------------
   always @(negedge clk) begin
      exp_t e;
      ctl_t o;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o.pc_write    = ctl_if.pc_write;
         o.instr_write = ctl_if.instr_write;
         o.reg_write   = ctl_if.reg_write;
         o.mem_read    = ctl_if.mem_read;
         o.mem_write   = ctl_if.mem_write;
         o.iord        = ctl_if.iord;
         o.mem_to_reg  = ctl_if.mem_to_reg;
         o.reg_dst     = ctl_if.reg_dst;
         o.imm_zext    = ctl_if.imm_zext;
         o.alu_src_a   = ctl_if.alu_src_a;
         o.alu_src_b   = ctl_if.alu_src_b;
         o.alu_control = ctl_if.alu_control;
         o.pc_src      = ctl_if.pc_src;
         o.illegal_op  = ctl_if.illegal_op;
         check("state", 32'(ctl_if.state), 32'(e.st));
         check("ctl", 32'(o), 32'(e.c));
         check("rd_wr_excl", 32'(ctl_if.mem_read & ctl_if.mem_write), 32'd0);
      end
   end

   initial begin
      rst              = 1'b1;
      ctl_if.opcode    = 6'h00;
      ctl_if.funct     = 6'h00;
      ctl_if.zero      = 1'b0;
      ctl_if.mem_ready = 1'b1;
      @(posedge clk);
      #1;
      m_state = 0;

      // Reset held three cycles with mem_ready high: everything reads 0.
      for (int i = 0; i < 3; i++) step(1'b1, 6'h23, 6'h00, 1'b0, 1'b1);
      $display("reset held 3 cycles");

      run_instr("lw",   6'h23, 6'h00, 1'b0, 2, 3, 10);
      run_instr("sw",   6'h2B, 6'h00, 1'b0, 0, 0, 4);
      run_instr("add",  6'h00, 6'h20, 1'b0, 0, 0, 4);
      run_instr("slt",  6'h00, 6'h2A, 1'b0, 0, 0, 4);
      run_instr("sub",  6'h00, 6'h22, 1'b0, 0, 0, 4);
      run_instr("beq1", 6'h04, 6'h00, 1'b1, 0, 0, 3);
      run_instr("beq0", 6'h04, 6'h00, 1'b0, 0, 0, 3);
      run_instr("ori",  6'h0D, 6'h00, 1'b0, 0, 0, 4);
      run_instr("andi", 6'h0C, 6'h00, 1'b0, 0, 0, 4);
      run_instr("addi", 6'h08, 6'h00, 1'b0, 1, 0, 5);
      run_instr("j",    6'h02, 6'h00, 1'b0, 0, 0, 3);
      run_instr("ill",  6'h3F, 6'h00, 1'b0, 0, 0, 2);
      run_instr("illfn", 6'h00, 6'h03, 1'b0, 0, 0, 2);
      run_instr("sw_wait", 6'h2B, 6'h00, 1'b0, 0, 2, 6);

      // Reset while lw is stalled in MEMREAD.
      step(1'b0, 6'h23, 6'h00, 1'b0, 1'b1);
      step(1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
      step(1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
      step(1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
      step(1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
      step(1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
      $display("reset in MEMREAD");
      run_instr("j_after_rst", 6'h02, 6'h00, 1'b0, 0, 0, 3);

      @(negedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
